// File: rtl/ppu_mem_arbiter_pkg.sv
// ppu_pkg: PPU mode and DMA state types, memory window constants and a window helper
package ppu_pkg;
  typedef enum logic [1:0] {H_BLANK, V_BLANK, SCAN, DRAW} PPU_STATES_t;
  typedef enum logic [1:0] {IDLE, START, READ, WRITE} DMA_STATES_t;
  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_END     = 16'h9FFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_END      = 16'hFE9F;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  function automatic logic in_win(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
    return a >= lo && a <= hi;
  endfunction
endpackage

// File: rtl/ppu_mem_arbiter_if.sv
// ppu_mem_arbiter_if: CPU, PPU and shared memory port signals of the arbiter
interface ppu_mem_arbiter_if;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_blocked;
  logic [1:0]  ppu_mode;
  logic        lcd_en;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ppu_mode, lcd_en, ppu_rd, ppu_addr, mem_rdata,
    input  cpu_rdata, cpu_blocked, ppu_rdata, mem_addr, mem_rd, mem_wr, mem_wdata, dma_active
  );
  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ppu_mode, lcd_en, ppu_rd, ppu_addr, mem_rdata,
    output cpu_rdata, cpu_blocked, ppu_rdata, mem_addr, mem_rd, mem_wr, mem_wdata, dma_active
  );
endinterface

// File: rtl/ppu_mem_arbiter_oam_dma.sv
// ppu_oam_dma: OAM DMA engine copying DMA_LEN bytes from {src,00} to FE00, restarted by any FF46 write
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int DMA_LEN     = 160,
  parameter int DMA_STARTUP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic        dma_req,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic [7:0]  dma_wdata
);
  localparam logic [7:0] LAST      = 8'(DMA_LEN - 1);
  localparam logic [7:0] LAST_WAIT = 8'(DMA_STARTUP - 1);
  DMA_STATES_t state, state_n;
  logic [7:0] idx, src, buf_q, wait_q;
  logic trig;
  assign trig = cpu_wr && cpu_addr == DMA_REG_ADDR;
  // state, index, source (echo RAM folded down) and byte buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      src    <= '0;
      buf_q  <= '0;
      wait_q <= '0;
    end else begin
      state <= state_n;
      if (trig) begin
        src    <= cpu_wdata >= 8'hE0 ? cpu_wdata - 8'h20 : cpu_wdata;
        idx    <= '0;
        wait_q <= '0;
      end else begin
        if (state == START) wait_q <= wait_q + 8'd1;
        if (state == READ) buf_q <= mem_rdata;
        if (state == WRITE) idx <= idx == LAST ? '0 : idx + 8'd1;
      end
    end
  end
  // next state: a trigger always restarts, otherwise alternate READ/WRITE until the last byte
  always_comb begin
    state_n = trig ? START :
              state == START ? (wait_q == LAST_WAIT ? READ : START) :
              state == READ  ? WRITE :
              state == WRITE ? (idx == LAST ? IDLE : READ) : IDLE;
  end
  assign dma_active = state != IDLE;
  assign dma_req    = state == READ || state == WRITE;
  assign dma_rd     = state == READ;
  assign dma_wr     = state == WRITE;
  assign dma_addr   = state == WRITE ? OAM_BASE + {8'h00, idx} : {src, 8'h00} + {8'h00, idx};
  assign dma_wdata  = buf_q;
endmodule

// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter: shares the memory port between OAM DMA, PPU and CPU; PPU_ARB_CONFLICT_CNT_EN adds conflict_cnt
module ppu_mem_arbiter
  import ppu_pkg::*;
#(
  parameter int DMA_LEN     = 160,
  parameter int DMA_STARTUP = 1
) (
  input logic clk,
  input logic rst,
  ppu_mem_arbiter_if.slave bus
`ifdef PPU_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);
  logic        dma_req, dma_rd, dma_wr;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        lcd_draw, lcd_scan, ppu_want, ppu_gnt, cpu_acc, cpu_gnt;
  ppu_oam_dma #(.DMA_LEN(DMA_LEN), .DMA_STARTUP(DMA_STARTUP)) u_dma (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (bus.cpu_addr),
    .cpu_wr    (bus.cpu_wr),
    .cpu_wdata (bus.cpu_wdata),
    .mem_rdata (bus.mem_rdata),
    .dma_active(bus.dma_active),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_rd    (dma_rd),
    .dma_wr    (dma_wr),
    .dma_wdata (dma_wdata)
  );
  assign lcd_draw = bus.lcd_en && bus.ppu_mode == DRAW;
  assign lcd_scan = bus.lcd_en && bus.ppu_mode == SCAN;
  assign ppu_want = bus.ppu_rd && ((lcd_scan && in_win(bus.ppu_addr, OAM_BASE, OAM_END)) ||
                                   (lcd_draw && in_win(bus.ppu_addr, VRAM_BASE, VRAM_END)));
  assign ppu_gnt  = ppu_want && !dma_req;
  assign cpu_acc  = (bus.cpu_rd || bus.cpu_wr) && bus.cpu_addr < IO_BASE;
  assign bus.cpu_blocked = cpu_acc && (bus.dma_active || ppu_want ||
                           (lcd_draw && in_win(bus.cpu_addr, VRAM_BASE, VRAM_END)) ||
                           ((lcd_draw || lcd_scan) && in_win(bus.cpu_addr, OAM_BASE, OAM_END)));
  assign cpu_gnt = cpu_acc && !bus.cpu_blocked;
  assign bus.mem_addr  = dma_req ? dma_addr : ppu_gnt ? bus.ppu_addr : cpu_gnt ? bus.cpu_addr : '0;
  assign bus.mem_rd    = dma_req ? dma_rd : ppu_gnt || (cpu_gnt && !bus.cpu_wr);
  assign bus.mem_wr    = dma_req ? dma_wr : cpu_gnt && bus.cpu_wr;
  assign bus.mem_wdata = dma_req ? dma_wdata : cpu_gnt ? bus.cpu_wdata : '0;
  assign bus.cpu_rdata = cpu_gnt && !bus.cpu_wr ? bus.mem_rdata : 8'hFF;
  assign bus.ppu_rdata = ppu_gnt ? bus.mem_rdata : 8'hFF;
`ifdef PPU_ARB_CONFLICT_CNT_EN
  // saturating count of refused CPU cycles, cleared by a DMA trigger
  always_ff @(posedge clk) begin
    if (rst || (bus.cpu_wr && bus.cpu_addr == DMA_REG_ADDR)) conflict_cnt <= '0;
    else if (bus.cpu_blocked && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb_ppu_mem_arbiter: directed checks of DMA, blocking, PPU grant, restart/echo and reset
module tb_ppu_mem_arbiter;
  import ppu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  ppu_mem_arbiter_if bus();
`ifdef PPU_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif
  ppu_mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PPU_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );
  always #5 clk = ~clk;
  logic [7:0] mem [65536];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
    bus.cpu_wr = 1'b1;
    step();
    bus.cpu_wr = 1'b0;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp, input logic expb);
    bus.cpu_addr = a;
    bus.cpu_rd = 1'b1;
    #1;
    check({tag, " rdata"}, 16'(bus.cpu_rdata), 16'(exp));
    check({tag, " blocked"}, 16'(bus.cpu_blocked), 16'(expb));
    bus.cpu_rd = 1'b0;
  endtask

  task automatic ppu_read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus.ppu_addr = a;
    bus.ppu_rd = 1'b1;
    #1;
    check(tag, 16'(bus.ppu_rdata), 16'(exp));
    bus.ppu_rd = 1'b0;
  endtask

  task automatic count_dma(output int cnt);
    cnt = 0;
    while (bus.dma_active && cnt < 2000) begin
      cnt++;
      step();
    end
  endtask

  task automatic oam_chk(input string tag, input logic [7:0] key);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ key)) bad++;
    check(tag, 16'(bad), 16'd0);
  endtask

  initial begin
    bus.cpu_addr = '0; bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_wdata = '0;
    bus.ppu_mode = H_BLANK; bus.lcd_en = 0; bus.ppu_rd = 0; bus.ppu_addr = '0;
    step(); step();
    check("rst dma_active", 16'(bus.dma_active), 16'd0);
    check("rst mem_rd", 16'(bus.mem_rd), 16'd0);
    check("rst mem_wr", 16'(bus.mem_wr), 16'd0);
    check("rst cpu_rdata", 16'(bus.cpu_rdata), 16'h00FF);
    check("rst ppu_rdata", 16'(bus.ppu_rdata), 16'h00FF);
    check("rst blocked", 16'(bus.cpu_blocked), 16'd0);
    rst = 0;
    step();
    for (int i = 0; i < 160; i++) begin
      cpu_write(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
      cpu_write(16'hC100 + 16'(i), 8'(i) ^ 8'hA5);
    end
    cpu_write(16'h8000, 8'h11);
    cpu_write(16'h9800, 8'hA5);
    cpu_read_chk("wram readback", 16'hC003, 8'h59, 1'b0);
    bus.lcd_en = 1; bus.ppu_mode = DRAW;
    bus.cpu_addr = 16'hFF44; bus.cpu_rd = 1; #1;
    check("io rdata", 16'(bus.cpu_rdata), 16'h00FF);
    check("io blocked", 16'(bus.cpu_blocked), 16'd0);
    check("io no port", 16'(bus.mem_rd), 16'd0);
    bus.cpu_rd = 0; bus.lcd_en = 0; bus.ppu_mode = H_BLANK;

    cpu_write(DMA_REG_ADDR, 8'hC0);
    count_dma(n);
    check("dma basic cycles", 16'(n), 16'd321);
    oam_chk("dma basic oam", 8'h5A);
    check("dma last byte", 16'(mem[16'hFE9F]), 16'h00C5);

    cpu_write(DMA_REG_ADDR, 8'hC0);
    repeat (10) step();
    cpu_read_chk("dma cpu rd", 16'hC000, 8'hFF, 1'b1);
    bus.cpu_addr = 16'h8000; bus.cpu_wdata = 8'h77; bus.cpu_wr = 1; #1;
    check("dma cpu wr blocked", 16'(bus.cpu_blocked), 16'd1);
    step();
    bus.cpu_wr = 0;
    count_dma(n);
    cpu_read_chk("vram kept", 16'h8000, 8'h11, 1'b0);

    bus.lcd_en = 1; bus.ppu_mode = DRAW;
    cpu_read_chk("draw vram", 16'h8000, 8'hFF, 1'b1);
    cpu_read_chk("draw oam", 16'hFE01, 8'hFF, 1'b1);
    cpu_read_chk("draw wram", 16'hC002, 8'h58, 1'b0);
    bus.ppu_mode = H_BLANK;
    cpu_read_chk("hblank vram", 16'h8000, 8'h11, 1'b0);
    cpu_read_chk("hblank oam", 16'hFE01, 8'h5B, 1'b0);
    cpu_read_chk("hblank wram", 16'hC002, 8'h58, 1'b0);
    bus.ppu_mode = SCAN;
    cpu_read_chk("scan oam", 16'hFE01, 8'hFF, 1'b1);
    cpu_read_chk("scan vram", 16'h8000, 8'h11, 1'b0);

    ppu_read_chk("ppu scan oam", 16'hFE04, 8'h5E);
    ppu_read_chk("ppu scan vram", 16'h9800, 8'hFF);
    bus.ppu_mode = DRAW;
    ppu_read_chk("ppu draw vram", 16'h9800, 8'hA5);
    bus.ppu_addr = 16'h9800; bus.ppu_rd = 1;
    cpu_read_chk("cpu loses to ppu", 16'hC002, 8'hFF, 1'b1);
    check("ppu wins", 16'(bus.ppu_rdata), 16'h00A5);
    bus.ppu_rd = 0;
    bus.ppu_mode = V_BLANK;
    ppu_read_chk("ppu vblank", 16'hFE04, 8'hFF);
    bus.lcd_en = 0; bus.ppu_mode = DRAW;
    ppu_read_chk("ppu lcd off", 16'h9800, 8'hFF);
    cpu_read_chk("cpu lcd off vram", 16'h8000, 8'h11, 1'b0);
    bus.ppu_mode = H_BLANK;

    cpu_write(DMA_REG_ADDR, 8'hC0);
    repeat (49) step();
    cpu_write(DMA_REG_ADDR, 8'hE1);
    count_dma(n);
    check("restart cycles", 16'(n), 16'd321);
    oam_chk("echo oam", 8'hA5);

    cpu_write(DMA_REG_ADDR, 8'hC0);
    repeat (99) step();
    rst = 1;
    step();
    check("midrst dma_active", 16'(bus.dma_active), 16'd0);
    check("midrst mem_rd", 16'(bus.mem_rd), 16'd0);
    check("midrst mem_wr", 16'(bus.mem_wr), 16'd0);
    check("midrst cpu_rdata", 16'(bus.cpu_rdata), 16'h00FF);
    check("midrst ppu_rdata", 16'(bus.ppu_rdata), 16'h00FF);
    check("midrst blocked", 16'(bus.cpu_blocked), 16'd0);
    rst = 0;
    n = 0;
    repeat (400) begin
      if (bus.mem_wr) n++;
      step();
    end
    check("no wr after rst", 16'(n), 16'd0);
    check("partial first", 16'(mem[16'hFE00]), 16'h005A);
    check("partial last new", 16'(mem[16'hFE30]), 16'h006A);
    check("partial first old", 16'(mem[16'hFE31]), 16'h0094);
    check("partial end old", 16'(mem[16'hFE9F]), 16'h003A);

`ifdef PPU_ARB_CONFLICT_CNT_EN
    cpu_write(DMA_REG_ADDR, 8'hC0);
    check("cnt cleared", conflict_cnt, 16'd0);
    bus.cpu_addr = 16'hC000; bus.cpu_rd = 1;
    repeat (5) step();
    bus.cpu_rd = 0;
    check("cnt five", conflict_cnt, 16'd5);
    count_dma(n);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ppu_mem_arbiter.md
Name: ppu_mem_arbiter

Overview:
- Owns the single system-memory port (0000-FEFF) and shares it between three requesters: the OAM DMA engine, the PPU fetcher and the CPU.
- Contains the OAM DMA engine, triggered by CPU writes to FF46.
- Enforces Game Boy access blocking by PPU mode: VRAM locked in DRAW, OAM locked in SCAN/DRAW.
- Sits between the CPU bus decoder, the PPU and VRAM/OAM/WRAM.

Parameters:
DMA_LEN, 160, bytes per OAM DMA transfer
DMA_STARTUP, 1, idle cycles between the FF46 write and the first DMA read

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_addr  in  16  CPU address
cpu_rd  in  1  CPU read strobe
cpu_wr  in  1  CPU write strobe
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data
cpu_blocked  out  1  the CPU access this cycle was refused
ppu_mode  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
lcd_en  in  1  LCDC bit 7
ppu_rd  in  1  PPU read request
ppu_addr  in  16  PPU address
ppu_rdata  out  8  PPU read data
mem_addr  out  16  shared port address
mem_rd  out  1  shared port read
mem_wr  out  1  shared port write
mem_wdata  out  8  shared port write data
mem_rdata  in  8  shared port read data; combinational, valid the same cycle as mem_addr
dma_active  out  1  DMA in progress (START, READ or WRITE state)

Behaviour:
- Reset: dma_active=0, DMA state IDLE, index=0, source register=0. All mem strobes are 0. cpu_rdata and ppu_rdata read FF. cpu_blocked=0.
- Address windows:
  - VRAM = 8000-9FFF; OAM = FE00-FE9F.
  - CPU accesses at FF00-FFFF never use the port: cpu_blocked=0, cpu_rdata=FF. They are decoded elsewhere.
  - The one exception is a cpu_wr to FF46, which this block snoops.
- DMA FSM states: IDLE, START, READ, WRITE.
  - IDLE: on cpu_wr to FF46, latch src=cpu_wdata and go to START. If src >= E0, use src-20 (echo RAM).
  - START: wait DMA_STARTUP cycles, then go to READ.
  - READ: mem_addr={src,8'h00}+idx, mem_rd=1, latch mem_rdata into dma_buf, go to WRITE.
  - WRITE: mem_addr=FE00+idx, mem_wr=1, mem_wdata=dma_buf. idx increments; when idx reaches DMA_LEN-1 go to IDLE, otherwise go to READ.
  - Transfer time: 2*DMA_LEN+DMA_STARTUP cycles. dma_active deasserts the cycle after the final WRITE.
  - A new FF46 write in any state restarts the transfer: new src, idx=0, state START.
- Grant priority, evaluated each cycle combinationally:
  1. DMA, in READ or WRITE.
  2. PPU, when ppu_rd && lcd_en && ((ppu_mode==SCAN && addr in OAM) || (ppu_mode==DRAW && addr in VRAM)).
  3. CPU, when the CPU is not blocked.
- CPU blocked, for a cpu_rd or cpu_wr to 0000-FEFF, when any of these holds:
  - dma_active;
  - VRAM address and lcd_en and ppu_mode==DRAW;
  - OAM address and lcd_en and ppu_mode in {SCAN, DRAW};
  - the port is granted to a higher-priority requester.
- Blocked accesses: reads return FF, writes are dropped, and cpu_blocked=1 that cycle.
- PPU losing to DMA: ppu_rdata=FF. No stall is signalled; the PPU owns its own timing.
- Read data paths:
  - Granted reads: ppu_rdata and cpu_rdata = mem_rdata combinationally.
  - Ungranted reads: FF.
- With lcd_en=0 the PPU is never granted and the CPU has no mode-based blocking.
- Reset mid-DMA: the FSM aborts to IDLE. OAM bytes already written remain.
- cpu_rd and cpu_wr asserted together: the write takes precedence.

Optional Feature:
PPU_ARB_CONFLICT_CNT_EN
- Defined: adds output conflict_cnt, 16 bits, a saturating count of cycles with cpu_blocked=1. Clears on rst and on a cpu_wr to FF46.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package ppu_pkg holds:
  - PPU_STATES_t enum (H_BLANK, V_BLANK, SCAN, DRAW);
  - DMA_STATES_t enum (IDLE, START, READ, WRITE);
  - constants VRAM_BASE/END, OAM_BASE/END, DMA_REG_ADDR (FF46).
- Sub-module ppu_oam_dma: the DMA FSM, index, source register and buffer. It exports a request, address, rd/wr and wdata to the top.
- The top holds the priority mux and the blocking logic.

Test Plan:
- DMA basic: WRAM C000-C09F holds i^5A. Write FF46=C0 with lcd_en=0. Response: dma_active high for 321 cycles; afterwards OAM FE00+i = i^5A.
- CPU during DMA: during a transfer, cpu_rd C000 returns FF with cpu_blocked=1, and cpu_wr 8000 is dropped (VRAM unchanged).
- Mode blocking: lcd_en=1, ppu_mode=DRAW. A cpu_rd at 8000 gives FF and blocked; a cpu_rd at FE00 gives FF; a cpu_rd at C000 gives the data. With ppu_mode=H_BLANK, all three are granted.
- PPU grant: ppu_mode=SCAN, ppu_rd at FE04 gives ppu_rdata=mem[FE04]. A ppu_rd at 9800 in SCAN is not granted (FF). In DRAW, a ppu_rd at 9800 returns mem[9800].
- Restart and echo: write FF46=C0, then at cycle 50 write FF46=E1. The transfer restarts sourcing from C100, with a total of 321 cycles counted from the second write.
- Reset mid-DMA: assert rst at cycle 100. Response: dma_active=0 next cycle, no further mem_wr, all outputs at their reset values.
